// File: rtl/npcnn_feeder.sv
// Stream source for the npcnn convolution engine: buffers one image and one kernel,
// then on start plays go, image pixels on a, kernel taps on b, and waits for done.
module npcnn_feeder #(
    parameter int AS = 6,
    parameter int BS = 3,
    parameter int AW = 8,
    parameter int BW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          wr_kern,
    input  logic [5:0]    wr_addr,
    input  logic [BW-1:0] wr_data,
    input  logic          start,
    input  logic          done,
    output logic [AW-1:0] a,
    output logic [BW-1:0] b,
    output logic          go,
    output logic          busy,
    output logic          complete,
    output logic          proto_err,
    output logic [2:0]    dbg_state
);

    localparam int NI   = AS * AS;
    localparam int NK   = BS * BS;
    localparam int NMAX = (NI > NK) ? NI : NK;
    localparam int IW   = $clog2(NMAX);
    localparam int IMW  = $clog2(NI);
    localparam int KMW  = $clog2(NK);
    localparam logic [IW-1:0] IMG_LAST = IW'(NI - 1);
    localparam logic [IW-1:0] KER_LAST = IW'(NK - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEAD = 3'd1,
        S_IMG  = 3'd2,
        S_KER  = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, idx_nxt;
    logic [AW-1:0] a_d;
    logic [BW-1:0] b_d;
    logic          go_d, complete_d;
    logic          accept_start, accept_write;

    logic [AW-1:0] img [NI];
    logic [BW-1:0] ker [NK];

    assign dbg_state    = state_q;
    assign accept_start = (state_q == S_IDLE) && start;
    assign accept_write = (state_q == S_IDLE) && wr_en;

    // Host writes land only while idle; out-of-range addresses are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NI; i++) img[i] <= '0;
            for (int j = 0; j < NK; j++) ker[j] <= '0;
        end else if (accept_write) begin
            if (!wr_kern && (32'(wr_addr) < NI))
                img[wr_addr[IMW-1:0]] <= wr_data[AW-1:0];
            else if (wr_kern && (32'(wr_addr) < NK))
                ker[wr_addr[KMW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a        <= '0;
            b        <= '0;
            go       <= 1'b0;
            busy     <= 1'b0;
            complete <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a        <= a_d;
            b        <= b_d;
            go       <= go_d;
            busy     <= (state_d != S_IDLE);
            complete <= complete_d;
        end
    end

    // Early done is flagged but never cuts the stream short.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            proto_err <= 1'b0;
        else if (accept_start)
            proto_err <= 1'b0;
        else if (done && (state_q == S_LEAD || state_q == S_IMG || state_q == S_KER))
            proto_err <= 1'b1;
    end

    // Output registers are loaded with the value the next state presents.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a;
        b_d        = b;
        go_d       = go;
        complete_d = 1'b0;
        idx_nxt    = idx_q + IW'(1);
        case (state_q)
            S_IDLE: begin
                a_d  = '0;
                b_d  = '0;
                go_d = 1'b0;
                if (start) begin
                    state_d = S_LEAD;
                    go_d    = 1'b1;
                end
            end
            S_LEAD: begin
                state_d = S_IMG;
                idx_d   = '0;
                a_d     = img[0];
            end
            S_IMG: begin
                if (idx_q == IMG_LAST) begin
                    state_d = S_KER;
                    idx_d   = '0;
                    b_d     = ker[0];
                end else begin
                    idx_d = idx_nxt;
                    a_d   = img[idx_nxt[IMW-1:0]];
                end
            end
            S_KER: begin
                if (idx_q == KER_LAST) begin
                    state_d = S_WAIT;
                end else begin
                    idx_d = idx_nxt;
                    b_d   = ker[idx_nxt[KMW-1:0]];
                end
            end
            S_WAIT: begin
                if (done) begin
                    state_d    = S_IDLE;
                    a_d        = '0;
                    b_d        = '0;
                    go_d       = 1'b0;
                    complete_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                go_d    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_npcnn_feeder.sv
// Directed bench for npcnn_feeder: loads buffers, runs streams and checks every
// edge of each run against hand-built expected image/kernel tables.
module tb_npcnn_feeder;

    localparam int AW = 8;
    localparam int BW = 9;
    localparam int NI = 36;
    localparam int NK = 9;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic          wr_kern;
    logic [5:0]    wr_addr;
    logic [BW-1:0] wr_data;
    logic          start;
    logic          done;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          go;
    logic          busy;
    logic          complete;
    logic          proto_err;
    logic [2:0]    dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    logic [AW-1:0] exp_img [NI];
    logic [BW-1:0] exp_ker [NK];

    npcnn_feeder #(.AS(6), .BS(3), .AW(AW), .BW(BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_kern   (wr_kern),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .done      (done),
        .a         (a),
        .b         (b),
        .go        (go),
        .busy      (busy),
        .complete  (complete),
        .proto_err (proto_err),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic kern, input int addr, input logic [BW-1:0] data);
        wr_en   = 1'b1;
        wr_kern = kern;
        wr_addr = 6'(addr);
        wr_data = data;
        tick();
        wr_en = 1'b0;
        if (!kern && addr < NI) exp_img[addr] = data[AW-1:0];
        else if (kern && addr < NK) exp_ker[addr] = data;
    endtask

    // One full run. done_at pulses done mid-stream, poke_at tries a write+start
    // while busy, reset_at aborts with an async reset; 0 disables each.
    task automatic run(input int done_at, input int poke_at, input int reset_at,
                       input bit sw_en, input int sw_addr, input logic [AW-1:0] sw_data);
        logic          perr;
        logic [AW-1:0] ea;
        logic [BW-1:0] eb;
        perr  = 1'b0;
        start = 1'b1;
        if (sw_en) begin
            wr_en   = 1'b1;
            wr_kern = 1'b0;
            wr_addr = 6'(sw_addr);
            wr_data = {1'b0, sw_data};
            exp_img[sw_addr] = sw_data;
        end
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        check("lead_go", 32'(go), 32'd1);
        check("lead_busy", 32'(busy), 32'd1);
        check("lead_a", 32'(a), 32'd0);
        check("lead_b", 32'(b), 32'd0);
        check("lead_perr", 32'(proto_err), 32'd0);
        for (int e = 2; e <= 48; e++) begin
            if (e == done_at) done = 1'b1;
            if (e == poke_at) begin
                wr_en   = 1'b1;
                wr_kern = 1'b0;
                wr_addr = 6'd0;
                wr_data = 9'h0AA;
                start   = 1'b1;
            end
            tick();
            done  = 1'b0;
            wr_en = 1'b0;
            start = 1'b0;
            if (e == done_at) perr = 1'b1;
            if (e <= 37) begin
                ea = exp_img[e-2];
                eb = '0;
            end else if (e <= 46) begin
                ea = exp_img[NI-1];
                eb = exp_ker[e-38];
            end else begin
                ea = exp_img[NI-1];
                eb = exp_ker[NK-1];
            end
            check($sformatf("a@%0d", e), 32'(a), 32'(ea));
            check($sformatf("b@%0d", e), 32'(b), 32'(eb));
            check($sformatf("go@%0d", e), 32'(go), 32'd1);
            check($sformatf("busy@%0d", e), 32'(busy), 32'd1);
            check($sformatf("perr@%0d", e), 32'(proto_err), 32'(perr));
            if (e == reset_at) begin
                #2 reset = 1'b1;
                #1;
                check("rst_go", 32'(go), 32'd0);
                check("rst_a", 32'(a), 32'd0);
                check("rst_b", 32'(b), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                #2 reset = 1'b0;
                for (int i = 0; i < NI; i++) exp_img[i] = '0;
                for (int j = 0; j < NK; j++) exp_ker[j] = '0;
                return;
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        check("end_go", 32'(go), 32'd0);
        check("end_complete", 32'(complete), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_a", 32'(a), 32'd0);
        check("end_b", 32'(b), 32'd0);
        check("end_perr", 32'(proto_err), 32'(perr));
        tick();
        check("post_complete", 32'(complete), 32'd0);
    endtask

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_kern = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        done    = 1'b0;
        for (int i = 0; i < NI; i++) exp_img[i] = '0;
        for (int j = 0; j < NK; j++) exp_ker[j] = '0;

        #2 reset = 1'b1;
        #1;
        check("reset_a", 32'(a), 32'd0);
        check("reset_b", 32'(b), 32'd0);
        check("reset_go", 32'(go), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_complete", 32'(complete), 32'd0);
        check("reset_perr", 32'(proto_err), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        tick();

        for (int i = 0; i < NI; i++) host_write(1'b0, i, 9'(i + 1));
        for (int j = 0; j < NK; j++) host_write(1'b1, j, 9'h100 + 9'(j));

        run(0, 0, 0, 1'b0, 0, 8'h00);
        run(0, 5, 0, 1'b0, 0, 8'h00);
        run(0, 0, 0, 1'b0, 0, 8'h00);
        run(10, 0, 0, 1'b0, 0, 8'h00);
        run(0, 0, 0, 1'b0, 0, 8'h00);
        run(0, 0, 0, 1'b1, 3, 8'h77);

        host_write(1'b0, 36, 9'h055);
        host_write(1'b1, 9, 9'h1FF);
        host_write(1'b0, 63, 9'h0CC);
        run(0, 0, 0, 1'b0, 0, 8'h00);

        run(0, 0, 40, 1'b0, 0, 8'h00);
        tick();
        run(0, 0, 0, 1'b0, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/npcnn_feeder.md
# npcnn_feeder

Stream source for the `npcnn` convolution engine. It holds one AS×AS image and one BS×BS kernel in local register buffers loaded through a host write port. On `start` it drives the engine's input protocol: `go`, then image pixels on `a` one per cycle in raster order, then kernel taps on `b` one per cycle. It then holds `go` until the engine reports `done`. It sits between the host/configuration logic and the `npcnn` input ports `a`, `b` and `go`.

## Interface
- AS, 6, image side length (image has AS*AS pixels)
- BS, 3, kernel side length (kernel has BS*BS taps)
- AW, 8, image pixel width
- BW, 9, kernel tap width
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- wr_en  input  1  host write strobe
- wr_kern  input  1  0 = image buffer, 1 = kernel buffer
- wr_addr  input  6  raster index (row*side + col)
- wr_data  input  BW  write data; image writes use bits [AW-1:0]
- start  input  1  launch request, sampled each cycle
- done  input  1  engine completion, from `npcnn`
- a  output  AW  image pixel to engine
- b  output  BW  kernel tap to engine
- go  output  1  engine run enable
- busy  output  1  high in any state other than IDLE
- complete  output  1  one-cycle pulse at end of a run
- proto_err  output  1  sticky: `done` seen before the stream finished

## Operation
- Buffers: AS*AS×AW image registers and BS*BS×BW kernel registers. Reset clears them to 0.
- Writes are accepted only when `busy`=0. A write to an address ≥ AS*AS (image) or ≥ BS*BS (kernel) is dropped silently. A write while busy is dropped.
- FSM states are IDLE, LEAD, IMG, KER, WAIT:
  - IDLE: `go`=0, `a`=0, `b`=0. `start`=1 moves to LEAD.
  - LEAD: `go`=1, `a`=0, `b`=0. Lasts 1 cycle, then IMG with idx=0.
  - IMG: `a`=img[idx], idx increments each cycle. After idx=AS*AS-1 the next state is KER with idx=0.
  - KER: `b`=ker[idx], and `a` holds the last image pixel img[AS*AS-1]. After idx=BS*BS-1 the next state is WAIT.
  - WAIT: `a` and `b` hold their last values and `go`=1. `done`=1 moves to IDLE and pulses `complete`.
- `done`=1 in LEAD, IMG or KER:
  - sets `proto_err`;
  - the stream is not aborted and completes normally;
  - WAIT still requires a fresh `done` to exit.
- `proto_err` clears only on reset or on an accepted `start`.
- `start` is ignored while `busy`=1. `start` together with `wr_en` in IDLE: the write is performed and the run starts; the written value is used.
- The index counter is wide enough for max(AS*AS, BS*BS)-1. With defaults it is 6 bits; no wrap occurs within a phase.

## Timing
- Reset values: `a`=0, `b`=0, `go`=0, `busy`=0, `complete`=0, `proto_err`=0, state IDLE, all buffers 0. Reset asserted mid-run returns to IDLE immediately (asynchronously) and drops `go` the same instant.
- All outputs are registered. Let edge 0 be the edge that samples `start`=1 in IDLE:
  - edge 1: `go`=1, `busy`=1 (LEAD).
  - edges 2 .. 1+AS*AS: `a`=img[0..AS*AS-1], i.e. edges 2..37 for defaults.
  - edges 2+AS*AS .. 1+AS*AS+BS*BS: `b`=ker[0..BS*BS-1], i.e. edges 38..46.
  - edge 2+AS*AS+BS*BS onward: WAIT.
- If `done` is sampled high at edge N in WAIT:
  - edge N+1: `go`=0, `a`=0, `b`=0, `busy`=0, `complete`=1;
  - edge N+2: `complete`=0.
- Minimum run length from `start` to `complete` is AS*AS+BS*BS+3 cycles, given `done` on the first WAIT cycle.
- A new `start` is accepted on the cycle `complete` is high, since the block is in IDLE.

## Test plan
- Reset, then load image img[i]=i+1 and kernel ker[j]=9'h100+j, then pulse `start` and hold `done`=0. Required:
  - `go` rises 1 edge after `start`;
  - `a` = 1..36 on edges 2..37;
  - `b` = 0x100..0x108 on edges 38..46;
  - `a` stays 36 during KER;
  - `go` stays high.
- From WAIT, pulse `done` for 1 cycle. Required: `go`=0 and `complete`=1 exactly one cycle later, `busy`=0, `a`=`b`=0, `proto_err`=0.
- During IMG, write img[0]=8'hAA and pulse `start`. Required: the streamed sequence is unchanged; after completion a readback run shows img[0] as its old value.
- Pulse `done` at edge 10, mid-IMG. Required: `proto_err`=1 and the stream continues to KER/WAIT. A second `done` in WAIT completes the run. The next accepted `start` clears `proto_err`.
- Assert `reset` during KER at edge 40. Required: `go`, `a`, `b`, `busy` go to 0 without a clock edge. A following `start` streams all-zero data, because the buffers were cleared.
- Write to image address 36 and to kernel address 9. Required: no buffer change, verified by a full run.
